// File: rtl/hidden_layer_seq_pkg.sv
// Shared configuration for the RBM hidden-layer stage: FSM states, port and
// accumulator width helpers.
package hidden_layer_seq_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, ACT, DONE} state_e;

  function automatic int port_1d(input int n, input int bl);
    return n * bl;
  endfunction

  function automatic int port_2d(input int n, input int m, input int bl);
    return n * m * bl;
  endfunction

  // Two full products summed in_dim times plus a sign bit cannot overflow.
  function automatic int acc_width(input int bl, input int n);
    return 2 * bl + $clog2(n) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hidden_layer_seq_hard_sigmoid.sv
// Hard sigmoid: floor-scale the accumulator, slope 1/4, offset 0.5, clamp to [0, 1.0].
module hard_sigmoid #(
  parameter int acc_w           = 28,
  parameter int input_bitlength = 12,
  parameter int frac_bits       = 8
) (
  input  logic signed [acc_w-1:0]           acc,
  output logic        [input_bitlength-1:0] h
);

  localparam logic signed [acc_w-1:0] ONE  = acc_w'(2 ** frac_bits);
  localparam logic signed [acc_w-1:0] HALF = acc_w'(2 ** (frac_bits - 1));

  logic signed [acc_w-1:0] z, y;

  always_comb begin
    z = acc >>> frac_bits;
    y = (z >>> 2) + HALF;
    if (y[acc_w-1])  h = '0;
    else if (y > ONE) h = input_bitlength'(ONE);
    else              h = input_bitlength'(y);
  end

endmodule

// File: rtl/hidden_layer_seq.sv
// Sequential RBM hidden layer: one MAC per clock, H[j] = hsig(b[j] + sum_i V[i]*W[i][j]).
// HiddenV is double-buffered so the downstream classifier only sees complete vectors.
module hidden_layer_seq
  import hidden_layer_seq_pkg::*;
#(
  parameter int input_bitlength = 12,
  parameter int frac_bits       = 8,
  parameter int in_dim          = 5,
  parameter int out_dim         = 5
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic [port_1d(in_dim, input_bitlength)-1:0]         VisibleV,
  input  logic [port_2d(in_dim, out_dim, input_bitlength)-1:0] H_WeightI,
  input  logic [port_1d(out_dim, input_bitlength)-1:0]        H_BiasI,
  output logic [port_1d(out_dim, input_bitlength)-1:0]        HiddenV,
  output logic                                                busy,
  output logic                                                done
);

  localparam int BL = input_bitlength;
  localparam int AW = acc_width(BL, in_dim);
  localparam int IW = idx_width(in_dim);
  localparam int JW = idx_width(out_dim);

  state_e state, state_nxt;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic signed [AW-1:0] acc;
  logic [in_dim*BL-1:0]  v_reg;
  logic [out_dim*BL-1:0] shadow, shadow_nxt;
  logic signed [BL-1:0]   v_el, w_el, b_el;
  logic signed [2*BL-1:0] prod;
  logic [BL-1:0] h;
  logic last_i, last_j;
  int ii, jj;

  hard_sigmoid #(.acc_w(AW), .input_bitlength(BL), .frac_bits(frac_bits)) u_hsig (
    .acc (acc),
    .h   (h)
  );

  always_comb begin
    ii         = int'(i);
    jj         = int'(j);
    v_el       = v_reg[ii*BL +: BL];
    w_el       = H_WeightI[(ii*out_dim + jj)*BL +: BL];
    b_el       = H_BiasI[jj*BL +: BL];
    prod       = v_el * w_el;
    shadow_nxt = shadow;
    shadow_nxt[jj*BL +: BL] = h;
    last_i     = (i == IW'(in_dim - 1));
    last_j     = (j == JW'(out_dim - 1));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = MAC;
      MAC:     if (last_i) state_nxt = ACT;
      ACT:     state_nxt = last_j ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      acc     <= '0;
      shadow  <= '0;
      HiddenV <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (start) begin
          v_reg <= VisibleV;
          j     <= '0;
        end
        LOAD: begin
          acc <= AW'(b_el) <<< frac_bits;
          i   <= '0;
        end
        MAC: begin
          acc <= acc + AW'(prod);
          i   <= i + IW'(1);
        end
        ACT: begin
          shadow <= shadow_nxt;
          // Publish on entry to DONE so done and the new vector appear together.
          if (last_j) HiddenV <= shadow_nxt;
          else        j       <= j + JW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Bench for hidden_layer_seq: directed corner runs plus random runs checked
// against an integer-arithmetic model of the hidden-layer equation.
module tb_hidden_layer_seq;

  localparam int BL  = 12;
  localparam int FB  = 8;
  localparam int ID  = 5;
  localparam int OD  = 5;
  localparam int LAT = OD * (ID + 2) + 1;

  logic clk = 1'b0;
  logic rst, start;
  logic [ID*BL-1:0]    VisibleV;
  logic [ID*OD*BL-1:0] H_WeightI;
  logic [OD*BL-1:0]    H_BiasI;
  logic [OD*BL-1:0]    HiddenV;
  logic busy, done;

  logic signed [BL-1:0] vv [ID];
  logic signed [BL-1:0] ww [ID][OD];
  logic signed [BL-1:0] bb [OD];

  int tests = 0;
  int fails = 0;

  hidden_layer_seq #(.input_bitlength(BL), .frac_bits(FB), .in_dim(ID), .out_dim(OD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .VisibleV  (VisibleV),
    .H_WeightI (H_WeightI),
    .H_BiasI   (H_BiasI),
    .HiddenV   (HiddenV),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < ID; i++) VisibleV[i*BL +: BL] = vv[i];
    for (int i = 0; i < ID; i++)
      for (int j = 0; j < OD; j++) H_WeightI[(i*OD + j)*BL +: BL] = ww[i][j];
    for (int j = 0; j < OD; j++) H_BiasI[j*BL +: BL] = bb[j];
  endtask

  // H[j] = clamp(floor(floor(b*2^FB + sum V*W) / 2^FB) / 4) + 0.5, [0, 1.0])
  function automatic logic [OD*BL-1:0] model();
    logic [OD*BL-1:0] r;
    longint acc, z, y;
    r = '0;
    for (int j = 0; j < OD; j++) begin
      acc = longint'(bb[j]) * (64'sd1 << FB);
      for (int i = 0; i < ID; i++) acc += longint'(vv[i]) * longint'(ww[i][j]);
      z = acc >>> FB;
      y = (z >>> 2) + (64'sd1 << (FB - 1));
      if (y < 0) y = 0;
      if (y > (64'sd1 << FB)) y = 64'sd1 << FB;
      r[j*BL +: BL] = y[BL-1:0];
    end
    return r;
  endfunction

  task automatic fill(input int v, input int w, input int b);
    for (int i = 0; i < ID; i++) vv[i] = BL'(v);
    for (int i = 0; i < ID; i++)
      for (int j = 0; j < OD; j++) ww[i][j] = BL'(w);
    for (int j = 0; j < OD; j++) bb[j] = BL'(b);
  endtask

  task automatic randomize_all();
    for (int i = 0; i < ID; i++) vv[i] = BL'(int'($urandom_range(0, 1023)) - 512);
    for (int i = 0; i < ID; i++)
      for (int j = 0; j < OD; j++) ww[i][j] = BL'(int'($urandom_range(0, 511)) - 256);
    for (int j = 0; j < OD; j++) bb[j] = BL'(int'($urandom_range(0, 2047)) - 1024);
  endtask

  // One start pulse; checks busy/done timing, HiddenV hold, and the final vector.
  // glitch also pulses start mid-run and in the DONE cycle, both of which must be ignored.
  task automatic run_check(input string tag, input bit glitch);
    logic [OD*BL-1:0] prev, exp;
    prev = HiddenV;
    exp  = model();
    @(negedge clk);
    drive();
    start = 1'b1;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      start = glitch && (c == 20 || c == LAT);
      chk({tag, "/busy"}, 64'(busy), 64'(c <= LAT));
      chk({tag, "/done"}, 64'(done), 64'(c == LAT));
      if (c < LAT)  chk({tag, "/hold"}, 64'(HiddenV), 64'(prev));
      else          chk({tag, "/H"},    64'(HiddenV), 64'(exp));
    end
    start = 1'b0;
  endtask

  initial begin
    logic [OD*BL-1:0] prev, exp;
    logic [OD*BL-1:0] pack_exp;
    rst = 1'b1;
    start = 1'b0;
    fill(0, 0, 0);
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset/H",    64'(HiddenV), 64'd0);
    chk("reset/busy", 64'(busy),    64'd0);
    chk("reset/done", 64'(done),    64'd0);
    rst = 1'b0;

    fill(0, 0, 0);
    vv[2] = 12'sd300;
    run_check("zero", 1'b0);
    chk("zero/H0", 64'(HiddenV[0 +: BL]), 64'd128);

    fill(256, 256, 0);
    run_check("upper", 1'b0);
    chk("upper/H4", 64'(HiddenV[4*BL +: BL]), 64'd256);

    fill(0, 0, -1024);
    run_check("lower", 1'b0);
    chk("lower/H2", 64'(HiddenV[2*BL +: BL]), 64'd0);

    fill(0, 0, -3);
    run_check("floor", 1'b1);
    chk("floor/H1", 64'(HiddenV[1*BL +: BL]), 64'd127);

    fill(0, 0, 0);
    vv[0] = 12'sd256;
    for (int j = 0; j < OD; j++) ww[0][j] = BL'(128 * j);
    run_check("pack", 1'b0);
    pack_exp = {12'd256, 12'd224, 12'd192, 12'd160, 12'd128};
    chk("pack/H", 64'(HiddenV), 64'(pack_exp));

    for (int k = 0; k < 4; k++) begin
      randomize_all();
      run_check("rand", k[0]);
    end

    // start held high: one run per LAT+1 cycles, V changed in each DONE cycle
    randomize_all();
    exp  = model();
    prev = HiddenV;
    @(negedge clk);
    drive();
    start = 1'b1;
    for (int c = 1; c <= 3 * (LAT + 1) - 1; c++) begin
      @(negedge clk);
      chk("held/busy", 64'(busy), 64'((c % (LAT + 1)) != 0));
      if ((c % (LAT + 1)) == LAT) begin
        chk("held/done", 64'(done), 64'd1);
        chk("held/H", 64'(HiddenV), 64'(exp));
        prev = HiddenV;
        for (int i = 0; i < ID; i++) vv[i] = BL'(int'($urandom_range(0, 1023)) - 512);
        drive();
        exp = model();
        if (c == 3 * (LAT + 1) - 1) start = 1'b0;
      end else begin
        chk("held/done", 64'(done), 64'd0);
        chk("held/hold", 64'(HiddenV), 64'(prev));
      end
    end
    @(negedge clk);
    chk("held/idle", 64'(busy), 64'd0);

    // reset mid-run, with start asserted alongside rst
    randomize_all();
    @(negedge clk);
    drive();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort/H",    64'(HiddenV), 64'd0);
    chk("abort/busy", 64'(busy),    64'd0);
    chk("abort/done", 64'(done),    64'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort/idle", 64'(busy), 64'd0);
    run_check("after_abort", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
